// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the decode stage.
//   - opcode / ALU code / ctrl bit-index localparams
//   - state_e FSM encoding
//   - decode_single(): {alu, ctrl} table for single-cycle and two-word opcodes
//   - op_legal / op_is_imm / op_is_seq opcode classifiers
package decode_pkg;

  localparam int OP_W    = 5;
  localparam int INSTR_W = 16;
  localparam int ALU_W   = 4;
  localparam int CTRL_W  = 21;

  localparam logic [OP_W-1:0] OP_BUBBLE = 5'h00;
  localparam logic [OP_W-1:0] OP_LDM    = 5'h01;
  localparam logic [OP_W-1:0] OP_STD    = 5'h02;
  localparam logic [OP_W-1:0] OP_ADD    = 5'h03;
  localparam logic [OP_W-1:0] OP_NOT    = 5'h04;
  localparam logic [OP_W-1:0] OP_NOP    = 5'h05;
  localparam logic [OP_W-1:0] OP_PUSH   = 5'h06;
  localparam logic [OP_W-1:0] OP_POP    = 5'h07;
  localparam logic [OP_W-1:0] OP_JZ     = 5'h08;
  localparam logic [OP_W-1:0] OP_JN     = 5'h09;
  localparam logic [OP_W-1:0] OP_JC     = 5'h0A;
  localparam logic [OP_W-1:0] OP_JMP    = 5'h0B;
  localparam logic [OP_W-1:0] OP_CALL   = 5'h0C;
  localparam logic [OP_W-1:0] OP_RET    = 5'h0D;
  localparam logic [OP_W-1:0] OP_RTI    = 5'h0E;
  localparam logic [OP_W-1:0] OP_INT    = 5'h0F;
  localparam logic [OP_W-1:0] OP_SETC   = 5'h10;
  localparam logic [OP_W-1:0] OP_CLRC   = 5'h11;
  localparam logic [OP_W-1:0] OP_LDD    = 5'h12;

  // ctrl bit positions, bit 20 = push down to bit 0 = mem_op
  localparam int unsigned CS_PUSH       = 20;
  localparam int unsigned CS_POP        = 19;
  localparam int unsigned CS_MEM_WRITE  = 18;
  localparam int unsigned CS_MEM_READ   = 17;
  localparam int unsigned CS_REG_WRITE  = 16;
  localparam int unsigned CS_ALU_OP     = 15;
  localparam int unsigned CS_IMM_SEL    = 14;
  localparam int unsigned CS_JZ         = 13;
  localparam int unsigned CS_JN         = 12;
  localparam int unsigned CS_JC         = 11;
  localparam int unsigned CS_JMP        = 10;
  localparam int unsigned CS_CALL       = 9;
  localparam int unsigned CS_RET        = 8;
  localparam int unsigned CS_RTI        = 7;
  localparam int unsigned CS_INT        = 6;
  localparam int unsigned CS_SETC       = 5;
  localparam int unsigned CS_CLRC       = 4;
  localparam int unsigned CS_FLAGS_WE   = 3;
  localparam int unsigned CS_BRANCH     = 2;
  localparam int unsigned CS_MEM_TO_REG = 1;
  localparam int unsigned CS_MEM_OP     = 0;

  localparam logic [ALU_W-1:0] ALU_NONE = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_PASS = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_NOT  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b1000;

  typedef enum logic [1:0] {IDLE, IMM, SEQ} state_e;

  typedef struct packed {
    logic [ALU_W-1:0]  alu;
    logic [CTRL_W-1:0] ctrl;
  } dec_t;

  function automatic logic [CTRL_W-1:0] cb(input int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_LDD;
  endfunction

  function automatic logic op_is_imm(input logic [OP_W-1:0] op);
    return (op == OP_LDM) || (op == OP_LDD);
  endfunction

  function automatic logic op_is_seq(input logic [OP_W-1:0] op);
    return (op == OP_CALL) || (op == OP_RTI) || (op == OP_INT);
  endfunction

  // Bubble, NOP, illegal and the sequenced opcodes all map to zero here;
  // the sequenced ones are expanded by uop_rom instead.
  function automatic dec_t decode_single(input logic [OP_W-1:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_LDM:  begin d.alu = ALU_PASS; d.ctrl = cb(CS_REG_WRITE) | cb(CS_IMM_SEL); end
      OP_STD:  d.ctrl = cb(CS_MEM_WRITE) | cb(CS_MEM_OP);
      OP_ADD:  begin d.alu = ALU_ADD; d.ctrl = cb(CS_REG_WRITE) | cb(CS_ALU_OP) | cb(CS_FLAGS_WE); end
      OP_NOT:  begin d.alu = ALU_NOT; d.ctrl = cb(CS_REG_WRITE) | cb(CS_ALU_OP) | cb(CS_FLAGS_WE); end
      OP_PUSH: d.ctrl = cb(CS_PUSH) | cb(CS_MEM_WRITE) | cb(CS_MEM_OP);
      OP_POP:  d.ctrl = cb(CS_POP) | cb(CS_MEM_READ) | cb(CS_MEM_OP) | cb(CS_REG_WRITE) | cb(CS_MEM_TO_REG);
      OP_JZ:   d.ctrl = cb(CS_JZ)  | cb(CS_BRANCH);
      OP_JN:   d.ctrl = cb(CS_JN)  | cb(CS_BRANCH);
      OP_JC:   d.ctrl = cb(CS_JC)  | cb(CS_BRANCH);
      OP_JMP:  d.ctrl = cb(CS_JMP) | cb(CS_BRANCH);
      OP_RET:  d.ctrl = cb(CS_POP) | cb(CS_MEM_READ) | cb(CS_MEM_OP) | cb(CS_RET);
      OP_SETC: d.ctrl = cb(CS_SETC) | cb(CS_FLAGS_WE);
      OP_CLRC: d.ctrl = cb(CS_CLRC) | cb(CS_FLAGS_WE);
      OP_LDD:  d.ctrl = cb(CS_REG_WRITE) | cb(CS_MEM_READ) | cb(CS_MEM_OP) | cb(CS_MEM_TO_REG) | cb(CS_IMM_SEL);
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uop_rom.sv
// uop_rom: combinational micro-op table for the multi-cycle opcodes.
//   op, step   -> opcode being sequenced and micro-op index
//   alu_ctrl   -> ALU select for this micro-op
//   ctrl       -> 21-bit control bundle for this micro-op
//   last       -> this is the final micro-op of the sequence
module uop_rom
  import decode_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        step,
  output logic [ALU_W-1:0]  alu_ctrl,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last
);

  always_comb begin
    alu_ctrl = ALU_NONE;
    ctrl     = '0;
    last     = 1'b1;
    case (op)
      OP_CALL: begin
        if (step == 2'd0) begin
          ctrl = cb(CS_PUSH) | cb(CS_MEM_WRITE) | cb(CS_MEM_OP);
          last = 1'b0;
        end else begin
          ctrl = cb(CS_CALL);
        end
      end
      OP_RTI: begin
        if (step == 2'd0) begin
          ctrl = cb(CS_POP) | cb(CS_MEM_READ) | cb(CS_RET);
          last = 1'b0;
        end else begin
          ctrl = cb(CS_POP) | cb(CS_MEM_READ) | cb(CS_RTI);
        end
      end
      OP_INT: begin
        if (step < 2'd2) begin
          ctrl = cb(CS_PUSH) | cb(CS_MEM_WRITE) | cb(CS_INT);
          last = 1'b0;
        end else begin
          ctrl = cb(CS_INT) | cb(CS_JMP);
        end
      end
      default: begin
        alu_ctrl = ALU_NONE;
        ctrl     = '0;
        last     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// decode_sequencer: registered decode stage feeding the ID/EX buffer.
//   clk, rst_n          clock, async active-low reset
//   instr/instr_valid/instr_ready   fetch handshake (opcode or immediate word)
//   stall, flush        hazard hold; branch/interrupt flush (flush wins)
//   alu_ctrl, ctrl      registered control bundle for the current micro-op
//   imm                 captured immediate for LDM/LDD
//   uop_step            micro-op index within the current instruction
//   illegal_op          one-cycle pulse on an unknown opcode
module decode_sequencer #(
  parameter int OP_W    = 5,
  parameter int INSTR_W = 16,
  parameter int ALU_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic [20:0]        ctrl,
  output logic [INSTR_W-1:0] imm,
  output logic [1:0]         uop_step,
  output logic               illegal_op
);
  import decode_pkg::*;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    pend_op_q, pend_op_d;   // LDM/LDD awaiting imm, or op being sequenced
  logic [1:0]         step_q, step_d;
  logic [ALU_W-1:0]   alu_q, alu_d;
  logic [20:0]        ctrl_q, ctrl_d;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic               illegal_q, illegal_d;

  logic [OP_W-1:0]    opcode;
  logic               accept;
  dec_t               in_dec, pend_dec;
  logic [OP_W-1:0]    rom_op;
  logic [1:0]         rom_step;
  logic [ALU_W-1:0]   rom_alu;
  logic [20:0]        rom_ctrl;
  logic               rom_last;

  assign opcode      = instr[INSTR_W-1 -: OP_W];
  assign instr_ready = (state_q != SEQ) && !stall && !flush;
  assign accept      = instr_valid && instr_ready;
  assign in_dec      = decode_single(opcode);
  assign pend_dec    = decode_single(pend_op_q);

  // In IDLE the ROM looks at the incoming opcode's first uop; in SEQ it
  // supplies the uop after the one currently on the outputs.
  assign rom_op   = (state_q == SEQ) ? pend_op_q : opcode;
  assign rom_step = (state_q == SEQ) ? step_q + 2'd1 : 2'd0;

  uop_rom u_rom (
    .op       (rom_op),
    .step     (rom_step),
    .alu_ctrl (rom_alu),
    .ctrl     (rom_ctrl),
    .last     (rom_last)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_op_q <= '0;
      step_q    <= '0;
      alu_q     <= '0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_op_q <= pend_op_d;
      step_q    <= step_d;
      alu_q     <= alu_d;
      ctrl_q    <= ctrl_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (!stall) begin
      case (state_q)
        IDLE: if (accept && op_legal(opcode)) begin
                if (op_is_imm(opcode))      state_d = IMM;
                else if (op_is_seq(opcode)) state_d = SEQ;
              end
        IMM:  if (accept) state_d = IDLE;
        SEQ:  if (rom_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // outputs (registered bundle)
  always_comb begin
    pend_op_d = pend_op_q;
    step_d    = step_q;
    alu_d     = alu_q;
    ctrl_d    = ctrl_q;
    imm_d     = imm_q;
    // illegal_op is a strict one-cycle pulse, so it drops even under stall
    illegal_d = 1'b0;
    if (flush) begin
      step_d = '0;
      alu_d  = '0;
      ctrl_d = '0;
    end else if (!stall) begin
      // bubble unless something below overrides it
      step_d = '0;
      alu_d  = '0;
      ctrl_d = '0;
      case (state_q)
        IDLE: if (accept) begin
                pend_op_d = opcode;
                if (!op_legal(opcode)) begin
                  illegal_d = 1'b1;
                end else if (op_is_seq(opcode)) begin
                  alu_d  = rom_alu;
                  ctrl_d = rom_ctrl;
                end else if (!op_is_imm(opcode)) begin
                  alu_d  = in_dec.alu;
                  ctrl_d = in_dec.ctrl;
                end
              end
        // the word here is data only; its top bits are never decoded
        IMM:  if (accept) begin
                alu_d  = pend_dec.alu;
                ctrl_d = pend_dec.ctrl;
                imm_d  = instr;
              end
        SEQ:  begin
                alu_d  = rom_alu;
                ctrl_d = rom_ctrl;
                step_d = rom_step;
              end
        default: ;
      endcase
    end
  end

  assign alu_ctrl   = alu_q;
  assign ctrl       = ctrl_q;
  assign imm        = imm_q;
  assign uop_step   = step_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_decode_sequencer.sv
module tb_decode_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_ctrl;
  logic [20:0] ctrl;
  logic [15:0] imm;
  logic [1:0]  uop_step;
  logic        illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  // hand-computed control words (bit 20 push ... bit 0 mem_op)
  localparam logic [20:0] C_ADD   = 21'h18008;  // reg_write|alu_op|flags_we
  localparam logic [20:0] C_LDM   = 21'h14000;  // reg_write|imm_sel
  localparam logic [20:0] C_LDD   = 21'h34003;
  localparam logic [20:0] C_CALL0 = 21'h140001; // push|mem_write|mem_op
  localparam logic [20:0] C_RTI0  = 21'hA0100;  // pop|mem_read|ret
  localparam logic [20:0] C_RTI1  = 21'hA0080;  // pop|mem_read|rti
  localparam logic [20:0] C_INT01 = 21'h140040; // push|mem_write|int
  localparam logic [20:0] C_INT2  = 21'h000440; // int|jmp

  decode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall(stall), .flush(flush),
    .alu_ctrl(alu_ctrl), .ctrl(ctrl), .imm(imm), .uop_step(uop_step),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // offer a word, check ready just after driving, then advance to next negedge
  task automatic offer(input logic [15:0] w, input logic v, input logic exp_rdy, input string tag);
    instr = w; instr_valid = v;
    #1 chk({tag, ".rdy"}, 32'(instr_ready), 32'(exp_rdy));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ctrl", 32'(ctrl), 0);
    chk("rst.alu", 32'(alu_ctrl), 0);
    chk("rst.rdy", 32'(instr_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-INT
    offer(16'h7800, 1'b1, 1'b1, "int0");
    chk("mint.u0.ctrl", 32'(ctrl), 32'(C_INT01));
    offer(16'h0000, 1'b0, 1'b0, "int1");
    chk("mint.u1.step", 32'(uop_step), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst.ctrl", 32'(ctrl), 0);
    chk("mrst.alu", 32'(alu_ctrl), 0);
    chk("mrst.imm", 32'(imm), 0);
    chk("mrst.step", 32'(uop_step), 0);
    chk("mrst.ill", 32'(illegal_op), 0);
    chk("mrst.rdy", 32'(instr_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    offer(16'h1800, 1'b1, 1'b1, "add");
    chk("radd.alu", 32'(alu_ctrl), 32'h8);
    chk("radd.ctrl", 32'(ctrl), 32'(C_ADD));

    // back-to-back ADD, NOT, NOP
    offer(16'h1800, 1'b1, 1'b1, "b2b.add");
    chk("b2b.add.alu", 32'(alu_ctrl), 32'h8);
    chk("b2b.add.ctrl", 32'(ctrl), 32'(C_ADD));
    offer(16'h2000, 1'b1, 1'b1, "b2b.not");
    chk("b2b.not.alu", 32'(alu_ctrl), 32'h4);
    chk("b2b.not.ctrl", 32'(ctrl), 32'(C_ADD));
    offer(16'h2800, 1'b1, 1'b1, "b2b.nop");
    chk("b2b.nop.alu", 32'(alu_ctrl), 0);
    chk("b2b.nop.ctrl", 32'(ctrl), 0);

    // LDM, gap, immediate 0xBEEF (top bits 0x17 must not decode)
    offer(16'h0800, 1'b1, 1'b1, "ldm");
    chk("ldm.bub1", 32'(ctrl), 0);
    offer(16'h0000, 1'b0, 1'b1, "ldm.gap");
    chk("ldm.bub2", 32'(ctrl), 0);
    chk("ldm.bub2.alu", 32'(alu_ctrl), 0);
    offer(16'hBEEF, 1'b1, 1'b1, "ldm.imm");
    chk("ldm.ctrl", 32'(ctrl), 32'(C_LDM));
    chk("ldm.alu", 32'(alu_ctrl), 32'h2);
    chk("ldm.imm", 32'(imm), 32'hBEEF);
    chk("ldm.ill", 32'(illegal_op), 0);

    // LDD with immediate, no gap; bubble keeps imm
    offer(16'h9000, 1'b1, 1'b1, "ldd");
    chk("ldd.bub", 32'(ctrl), 0);
    chk("ldd.bub.imm", 32'(imm), 32'hBEEF);
    offer(16'h0042, 1'b1, 1'b1, "ldd.imm");
    chk("ldd.ctrl", 32'(ctrl), 32'(C_LDD));
    chk("ldd.imm", 32'(imm), 32'h0042);

    // RTI two uops
    offer(16'h7000, 1'b1, 1'b1, "rti");
    chk("rti.u0", 32'(ctrl), 32'(C_RTI0));
    offer(16'h0000, 1'b0, 1'b0, "rti1");
    chk("rti.u1", 32'(ctrl), 32'(C_RTI1));
    chk("rti.u1.step", 32'(uop_step), 1);

    // INT with 2-cycle stall during uop 1; ADD held waiting behind it
    offer(16'h7800, 1'b1, 1'b1, "sint");
    chk("sint.s0", 32'(uop_step), 0);
    chk("sint.int0", 32'(ctrl[6]), 1);
    offer(16'h1800, 1'b1, 1'b0, "sint.w1");
    chk("sint.s1", 32'(uop_step), 1);
    chk("sint.int1", 32'(ctrl[6]), 1);
    stall = 1'b1;
    offer(16'h1800, 1'b1, 1'b0, "sint.st1");
    chk("sint.s1a", 32'(uop_step), 1);
    chk("sint.int1a", 32'(ctrl), 32'(C_INT01));
    offer(16'h1800, 1'b1, 1'b0, "sint.st2");
    chk("sint.s1b", 32'(uop_step), 1);
    stall = 1'b0;
    offer(16'h1800, 1'b1, 1'b0, "sint.w2");
    chk("sint.s2", 32'(uop_step), 2);
    chk("sint.ctrl2", 32'(ctrl), 32'(C_INT2));
    offer(16'h1800, 1'b1, 1'b1, "sint.add");
    chk("sint.add.alu", 32'(alu_ctrl), 32'h8);
    chk("sint.add.step", 32'(uop_step), 0);

    // flush during CALL uop 1, with stall also high
    offer(16'h6000, 1'b1, 1'b1, "call");
    chk("call.u0", 32'(ctrl), 32'(C_CALL0));
    stall = 1'b1; flush = 1'b1;
    offer(16'h1800, 1'b1, 1'b0, "fl");
    chk("fl.ctrl", 32'(ctrl), 0);
    chk("fl.step", 32'(uop_step), 0);
    stall = 1'b0; flush = 1'b0;
    offer(16'h0000, 1'b0, 1'b1, "fl.idle");
    chk("fl.nouop1", 32'(ctrl), 0);

    // illegal opcode then ADD
    offer(16'hF800, 1'b1, 1'b1, "ill");
    chk("ill.pulse", 32'(illegal_op), 1);
    chk("ill.ctrl", 32'(ctrl), 0);
    offer(16'h1800, 1'b1, 1'b1, "ill.add");
    chk("ill.drop", 32'(illegal_op), 0);
    chk("ill.add.ctrl", 32'(ctrl), 32'(C_ADD));
    instr_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

Registered decode stage for the five-stage pipeline. It takes fetched instruction words over a valid/ready handshake and expands multi-cycle instructions (CALL, RTI, INT) into ordered micro-ops. It gathers the immediate word for two-word instructions (LDM, LDD). It drives one registered control bundle per cycle into the ID/EX buffer, and honours hazard stall and branch flush.

## Interface
- OP_W, 5, opcode width; the opcode is `instr[INSTR_W-1 -: OP_W]`
- INSTR_W, 16, instruction/immediate word width
- ALU_W, 4, ALU control field width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  INSTR_W  fetched word (opcode or immediate)
- instr_valid  in  1  fetch word valid
- instr_ready  out  1  word accepted at a rising edge when valid && ready
- stall  in  1  hazard stall; holds all state and outputs
- flush  in  1  branch/interrupt flush; priority over stall
- alu_ctrl  out  ALU_W  ALU select for the current micro-op
- ctrl  out  21  cs_push..cs_mem_op, bit 20 = push down to bit 0 = mem_op
- imm  out  INSTR_W  captured immediate (valid with LDM/LDD micro-op)
- uop_step  out  2  micro-op index within the current instruction
- illegal_op  out  1  one-cycle pulse on an unknown opcode

## Operation
- Opcodes:
  - 00 bubble; 01 LDM; 02 STD; 03 ADD; 04 NOT; 05 NOP; 06 PUSH; 07 POP
  - 08 JZ; 09 JN; 0A JC; 0B JMP; 0C CALL; 0D RET; 0E RTI; 0F INT
  - 10 SETC; 11 CLRC; 12 LDD
  - 13–1F illegal
- Single-cycle opcodes are decoded through the package constant table into {alu_ctrl, ctrl}.
- FSM states:
  - IDLE: ready = !stall. On accept:
    - single-cycle op: emit it, stay IDLE
    - LDM/LDD: go to IMM and emit a bubble
    - CALL/RTI/INT: emit uop 0 and go to SEQ
  - IMM: ready = !stall. The next accepted word is the immediate, never decoded. Emit LDM/LDD controls with imm = word, go to IDLE. While instr_valid = 0, emit a bubble and stay.
  - SEQ: ready = 0. Each non-stalled cycle emits the next uop; after the last, go to IDLE.
- Micro-op sequences:
  - CALL: (0) push + mem_write + mem_op; (1) call
  - RTI: (0) pop + mem_read + ret; (1) pop + mem_read + rti
  - INT: (0) push + mem_write + int; (1) push + mem_write + int; (2) int + jmp
- Bubble: all outputs zero except imm, which holds.
- Illegal opcode: emit a bubble, pulse illegal_op, stay IDLE.
- Stall: FSM, step counter and all outputs hold; ready = 0.
- Flush: at the next edge, outputs become a bubble and the FSM goes to IDLE, abandoning a partial sequence or pending immediate. A word offered in the same cycle is not accepted; ready = 0 while flush = 1.
- Reset (async, any state): FSM IDLE, alu_ctrl/ctrl/imm/uop_step/illegal_op = 0.

## Timing
- All outputs are registered. A word accepted at edge N takes effect on the outputs from edge N.
- Single-cycle ops: 1 instruction per cycle throughput.
- LDM/LDD: bubble after the opcode edge, controls after the immediate edge. Minimum 2 cycles.
- CALL/RTI: uops at edges N and N+1; ready low for the cycle after N.
- INT: uops at edges N, N+1, N+2; ready low for 2 cycles.
- A stall inserted mid-sequence extends it 1:1 with no uop lost or repeated.
- illegal_op is high exactly one cycle.

## Structure
- Package decode_pkg holds:
  - OP_W, opcode localparams
  - ctrl bit-index localparams (PUSH=20 … MEM_OP=0)
  - the ALU code localparams
  - state enum {IDLE, IMM, SEQ}
  - the single-cycle decode table function
- One sub-module, uop_rom: combinational (opcode, step) → {alu_ctrl, ctrl, last}. The FSM/register core stays in decode_sequencer.

## Test plan
- Reset mid-INT (after uop 1): all outputs 0 and instr_ready = 1 (no stall, no flush) while rst_n low; after release, ADD 0x1800 is accepted → alu_ctrl = 4'b1000, ctrl has reg_write and alu_op set.
- Back-to-back ADD, NOT, NOP with valid held high: three consecutive cycles of decoded controls, instr_ready constantly 1.
- LDM then immediate 0xBEEF, with one valid-low gap: bubble, bubble, then LDM controls with imm = 0xBEEF; the immediate is not decoded as opcode 0x17.
- INT with stall asserted during uop 1 for 2 cycles: uop_step sequence 0,1,1,1,2; ctrl int bit high for all; the next word is accepted only after step 2.
- Flush during CALL uop 1 with stall also high: next cycle bubble, state IDLE, instr_ready = 1.
- Opcode 0x1F: illegal_op high one cycle, outputs bubble, following valid ADD decoded normally.
